// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths, status indices, FSM states and operand layout for fpu_core
//
// Build option: FPU_RNE_EN selects round-to-nearest-even in fpu_rounder.
// If it is not defined, results are truncated (round toward zero).
package fpu_pkg;

  localparam int EXP_W = 6;    // stored exponent width
  localparam int MAN_W = 25;   // stored fraction width
  localparam int BIAS  = 31;   // exponent bias
  localparam int XW    = 8;    // internal exponent width, wide enough to hold 64/65 on overflow

  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  // Bit positions inside status_out
  localparam int ST_EXACT   = 3;
  localparam int ST_OVF     = 2;
  localparam int ST_UNF     = 1;
  localparam int ST_INEXACT = 0;

  typedef enum logic [2:0] {LOAD, ALIGN, ADD, NORM, ROUND, OUT} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_t;

  // Working mantissa {hidden, frac, guard, round}; a zero exponent means the value is zero.
  function automatic logic [MAN_W+2:0] work_mant(input fp_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.frac, 2'b00};
  endfunction

  function automatic logic [3:0] st_bit(input int idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/fpu_if.sv
// rtl/fpu_if.sv - operand/result bundle between a datapath master and fpu_core
//
// Signals: a, b (operands), op (bit 0 selects subtract), data_out (result), status_out (one-hot status)
// Modports: master drives operands and observes results; slave is the arithmetic unit.
interface fpu_if;
  import fpu_pkg::*;

  logic [EXP_W+MAN_W:0] a;
  logic [EXP_W+MAN_W:0] b;
  logic [1:0]           op;
  logic [EXP_W+MAN_W:0] data_out;
  logic [3:0]           status_out;

  modport master (output a, b, op, input data_out, status_out);
  modport slave  (input a, b, op, output data_out, status_out);

endinterface

// File: rtl/fpu_rounder.sv
// rtl/fpu_rounder.sv - combinational rounding of a normalized mantissa
//
// Ports:
//   mant     in  {frac, guard, round} of the normalized result (hidden bit excluded)
//   sticky   in  OR of every bit below the round bit
//   exp_in   in  exponent before rounding
//   frac_out out rounded fraction
//   exp_out  out exponent after a possible rounding carry
//   inexact  out any of guard/round/sticky was nonzero
// Build option: FPU_RNE_EN enables round-to-nearest-even, otherwise truncate.
module fpu_rounder
  import fpu_pkg::*;
(
  input  logic [MAN_W+1:0] mant,
  input  logic             sticky,
  input  logic [XW-1:0]    exp_in,
  output logic [MAN_W-1:0] frac_out,
  output logic [XW-1:0]    exp_out,
  output logic             inexact
);

  logic           round_up;
  logic [MAN_W:0] frac_inc;

  always_comb begin
    inexact = mant[1] | mant[0] | sticky;
`ifdef FPU_RNE_EN
    // Above half, or exactly half with an odd LSB, rounds up.
    round_up = mant[1] & (mant[0] | sticky | mant[2]);
`else
    round_up = 1'b0;
`endif
    frac_inc = {1'b0, mant[MAN_W+1:2]} + {{MAN_W{1'b0}}, round_up};
    frac_out = frac_inc[MAN_W-1:0];
    // An all-ones fraction rolling over becomes 1.0 at the next exponent.
    exp_out  = exp_in + {{(XW-1){1'b0}}, frac_inc[MAN_W]};
  end

endmodule

// File: rtl/fpu_core.sv
// rtl/fpu_core.sv - sequential add/subtract unit for the sign/6b-exp/25b-frac format
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    fpu_if.slave: a, b, op in; data_out, status_out out (registered)
// Runs LOAD -> ALIGN -> ADD -> NORM -> ROUND -> OUT forever; outputs change only in OUT.
// Build option: FPU_RNE_EN (see fpu_rounder).
module fpu_core
  import fpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fpu_if.slave bus
);

  localparam int MW = MAN_W + 3;  // {hidden, frac, guard, round}
  localparam int SW = MW + 2;     // {carry, mantissa, sticky}

  state_t state, next_state;

  fp_t fa, fb;
  logic          sa, sb, sta, stb;
  logic [XW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;

  logic          rs, rstk, carry;
  logic [XW-1:0] re;
  logic [MW-1:0] rm;

  logic             fin_sign, fin_zero, fin_unf, fin_inexact;
  logic [XW-1:0]    fin_exp;
  logic [MAN_W-1:0] fin_frac;

  logic [SW-1:0]    ext_a, ext_b, sum;
  logic             a_ge_b;
  logic [XW-1:0]    ediff;
  logic [MAN_W-1:0] rnd_frac;
  logic [XW-1:0]    rnd_exp;
  logic             rnd_inexact;

  assign fa = bus.a;
  assign fb = bus.b;

  // Sticky rides along as the lowest arithmetic bit: when subtracting, a set sticky
  // borrows one unit so the bits above it are the exact truncated difference.
  always_comb begin
    ext_a  = {1'b0, ma, sta};
    ext_b  = {1'b0, mb, stb};
    a_ge_b = (ext_a >= ext_b);
    if (sa == sb)    sum = ext_a + ext_b;
    else if (a_ge_b) sum = ext_a - ext_b;
    else             sum = ext_b - ext_a;
    ediff = (ea >= eb) ? (ea - eb) : (eb - ea);
  end

  fpu_rounder u_rounder (
    .mant     (rm[MW-2:0]),
    .sticky   (rstk),
    .exp_in   (re),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:  next_state = ALIGN;
      ALIGN: if (ea == eb) next_state = ADD;
      ADD:   next_state = NORM;
      NORM:  if (carry || rm == '0 || rm[MW-1] || re == '0) next_state = ROUND;
      ROUND: next_state = OUT;
      OUT:   next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa <= 1'b0; sb <= 1'b0; sta <= 1'b0; stb <= 1'b0;
      ea <= '0; eb <= '0; ma <= '0; mb <= '0;
      rs <= 1'b0; rstk <= 1'b0; carry <= 1'b0; re <= '0; rm <= '0;
      fin_sign <= 1'b0; fin_zero <= 1'b0; fin_unf <= 1'b0; fin_inexact <= 1'b0;
      fin_exp <= '0; fin_frac <= '0;
      bus.data_out   <= '0;
      bus.status_out <= '0;
    end else begin
      case (state)
        LOAD: begin
          sa  <= fa.sign;
          // Only op[0] matters; the reduction keeps op[1] a harmless don't-care.
          sb  <= fb.sign ^ (^(bus.op & 2'b01));
          ea  <= XW'(fa.exp);
          eb  <= XW'(fb.exp);
          ma  <= work_mant(fa);
          mb  <= work_mant(fb);
          sta <= 1'b0;
          stb <= 1'b0;
        end
        ALIGN: begin
          if (ea > eb) begin
            if (ediff > XW'(MW - 1)) begin
              mb <= '0; stb <= stb | (|mb); eb <= ea;
            end else begin
              mb <= mb >> 1; stb <= stb | mb[0]; eb <= eb + XW'(1);
            end
          end else if (eb > ea) begin
            if (ediff > XW'(MW - 1)) begin
              ma <= '0; sta <= sta | (|ma); ea <= eb;
            end else begin
              ma <= ma >> 1; sta <= sta | ma[0]; ea <= ea + XW'(1);
            end
          end
        end
        ADD: begin
          rs    <= (sa == sb || a_ge_b) ? sa : sb;
          re    <= ea;
          carry <= sum[SW-1];
          rm    <= sum[SW-2:1];
          rstk  <= sum[0];
        end
        NORM: begin
          if (carry) begin
            rm    <= {1'b1, rm[MW-1:1]};
            rstk  <= rstk | rm[0];
            re    <= re + XW'(1);
            carry <= 1'b0;
          end else if (rm != '0 && !rm[MW-1] && re != '0) begin
            // Sticky can only be set when a single left shift is needed; feeding it
            // into the round bit keeps round|sticky correct after that shift.
            rm <= {rm[MW-2:0], rstk};
            re <= re - XW'(1);
          end
        end
        ROUND: begin
          fin_sign    <= rs;
          fin_zero    <= (rm == '0);
          fin_unf     <= (re == '0);
          fin_frac    <= rnd_frac;
          fin_exp     <= rnd_exp;
          fin_inexact <= rnd_inexact;
        end
        OUT: begin
          if (fin_zero) begin
            bus.data_out   <= '0;
            bus.status_out <= st_bit(ST_EXACT);
          end else if (fin_exp > EXP_MAX) begin
            bus.data_out   <= {fin_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            bus.status_out <= st_bit(ST_OVF);
          end else if (fin_unf) begin
            bus.data_out   <= {fin_sign, {(EXP_W + MAN_W){1'b0}}};
            bus.status_out <= st_bit(ST_UNF);
          end else begin
            bus.data_out   <= {fin_sign, fin_exp[EXP_W-1:0], fin_frac};
            bus.status_out <= fin_inexact ? st_bit(ST_INEXACT) : st_bit(ST_EXACT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_core.sv
// tb/tb_fpu_core.sv - directed and randomized checks of fpu_core against an exact-arithmetic model
module tb_fpu_core;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  fpu_if bus();

  fpu_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Exact sum of the two encoded values, then truncated (or RNE) to 25 fraction bits.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic         sa, sb, sr, inexact;
    int           ea, eb, emin, p, e;
    logic [127:0] ma, mb, mag, rem;
    logic [24:0]  frac;
    sa = a[31];
    sb = b[31] ^ op[0];
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    if (ea == 0 && eb == 0) return {4'b1000, 32'h0};
    if (eb == 0) return {4'b1000, a};
    if (ea == 0) return {4'b1000, sb, b[30:0]};
    emin = (ea < eb) ? ea : eb;
    ma = {102'd0, 1'b1, a[24:0]} << (ea - emin);
    mb = {102'd0, 1'b1, b[24:0]} << (eb - emin);
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma > mb) begin
      mag = ma - mb; sr = sa;
    end else if (mb > ma) begin
      mag = mb - ma; sr = sb;
    end else begin
      return {4'b1000, 32'h0};
    end
    p = 127;
    while (p > 0 && !mag[p]) p--;
    e = p + emin - 25;
    rem = '0;
    if (p > 25) begin
      rem  = mag & ((128'd1 << (p - 25)) - 128'd1);
      frac = 25'(mag >> (p - 25));
    end else begin
      frac = 25'(mag << (25 - p));
    end
    inexact = (rem != '0);
    if (e < 1) return {4'b0010, sr, 31'd0};
`ifdef FPU_RNE_EN
    if (p > 25 && (rem > (128'd1 << (p - 26)) || (rem == (128'd1 << (p - 26)) && frac[0]))) begin
      if (frac == '1) begin frac = '0; e++; end
      else frac++;
    end
`endif
    if (e > 63) return {4'b0100, sr, 6'h3F, 25'h1FFFFFF};
    return {(inexact ? 4'b0001 : 4'b1000), sr, 6'(e), frac};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reset, present operands for the LOAD edge only, then wait (bounded) for the first OUT.
  task automatic run_vec(input logic [31:0] va, input logic [31:0] vb, input logic [1:0] vop,
                         input logic [31:0] exp_d, input logic [3:0] exp_s, input string tag);
    int k;
    @(negedge clk);
    reset = 1'b1;
    bus.a = va; bus.b = vb; bus.op = vop;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    check({tag, "_early_data"}, bus.data_out, 32'h0);
    check({tag, "_early_status"}, {28'd0, bus.status_out}, 32'h0);
    k = 1;
    while (bus.status_out == 4'b0000 && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    assert (k <= 64) else begin
      n_fails++;
      $error("FAIL %s_latency: observed %0d cycles expected <= 64", tag, k);
    end
    check({tag, "_data"}, bus.data_out, exp_d);
    check({tag, "_status"}, {28'd0, bus.status_out}, {28'd0, exp_s});
  endtask

  initial begin
    logic [31:0] ra, rb, ed;
    logic [1:0]  rop;
    logic [3:0]  es;
    int          bit_idx;

    reset = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(negedge clk);
    check("reset_data", bus.data_out, 32'h0);
    check("reset_status", {28'd0, bus.status_out}, 32'h0);

    run_vec(32'h00000000, 32'h00000000, 2'b00, 32'h00000000, 4'b1000, "zero_plus_zero");
    run_vec(32'h3E000000, 32'h3E000000, 2'b00, 32'h40000000, 4'b1000, "one_plus_one");

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop_reset_data", bus.data_out, 32'h0);
    check("midop_reset_status", {28'd0, bus.status_out}, 32'h0);

    run_vec(32'h3E000000, 32'hBE000000, 2'b00, 32'h00000000, 4'b1000, "one_plus_neg_one");
    run_vec(32'h3E000000, 32'h3E000000, 2'b01, 32'h00000000, 4'b1000, "one_minus_one");
    run_vec(32'h3E000000, 32'h3E000000, 2'b10, 32'h40000000, 4'b1000, "op10_add");
    run_vec(32'h3E000000, 32'h3E000000, 2'b11, 32'h00000000, 4'b1000, "op11_sub");
    run_vec(32'h3EFFFFFF, 32'h3E000001, 2'b00, 32'h40800000, 4'b1000, "sum_2p5");
    run_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 2'b00, 32'h7FFFFFFF, 4'b0100, "overflow");
    run_vec(32'h64000064, 32'h14000064, 2'b00, 32'h64000064, 4'b0001, "far_flush");
    run_vec(32'h00000000, 32'h3E000000, 2'b01, 32'hBE000000, 4'b1000, "zero_minus_b");
    run_vec(32'h02000000, 32'h02000001, 2'b01, 32'h80000000, 4'b0010, "underflow");
    run_vec(32'h3E000000, 32'h0A000000, 2'b00, 32'h3E000000, 4'b0001, "guard_only");

    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom);
      case ($urandom_range(0, 4))
        0: ;
        1: rb[30:25] = ra[30:25] + 6'($urandom_range(0, 2));
        2: begin
          rb[30:0] = ra[30:0];
          bit_idx = $urandom_range(0, 3);
          rb[bit_idx] = ~rb[bit_idx];
        end
        3: rb[30:25] = 6'd0;
        default: begin
          ra[30:25] = 6'($urandom_range(1, 2));
          rb[30:0]  = ra[30:0];
          bit_idx = $urandom_range(0, 24);
          rb[bit_idx] = ~rb[bit_idx];
          rb[31] = ra[31] ^ ~rop[0];
        end
      endcase
      {es, ed} = ref_model(ra, rb, rop);
      run_vec(ra, rb, rop, ed, es, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
